// File: rtl/risc_v_mike_dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the core (C) and debug (D) ports.
// Optional debug ownership lock enabled by defining RISC_V_MIKE_ARB_LOCK_EN.
module risc_v_mike_dmem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
`ifdef RISC_V_MIKE_ARB_LOCK_EN
  parameter int LOCK_MAX = 64,
`endif
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
`ifdef RISC_V_MIKE_ARB_LOCK_EN
  input  logic              d_lock,
`endif
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [CNT_W-1:0]  conflict_cnt
);

  logic last_win_d;
  logic rr_c, rr_d;
  logic c_win, d_win;
  logic last_win_nxt;

  // On a tie the port that did not win last time takes the beat.
  always_comb begin
    rr_c = c_req;
    rr_d = d_req;
    if (c_req && d_req) begin
      rr_c = last_win_d;
      rr_d = !last_win_d;
    end
  end

`ifdef RISC_V_MIKE_ARB_LOCK_EN
  // state     | meaning
  // ST_ARB    | round-robin between core and debug
  // ST_LOCKED | debug owns the memory; core is never granted
  typedef enum logic {ST_ARB, ST_LOCKED} state_t;

  localparam int LCNT_W = $clog2(LOCK_MAX + 1);

  state_t            state, state_nxt;
  logic [LCNT_W-1:0] lock_cnt, lock_cnt_nxt;
  logic              lock_ign, lock_ign_nxt;
  logic              lock_tmo;

  assign lock_tmo = (lock_cnt == LCNT_W'(LOCK_MAX - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_ARB;
      lock_cnt <= '0;
      lock_ign <= 1'b0;
    end else begin
      state    <= state_nxt;
      lock_cnt <= lock_cnt_nxt;
      lock_ign <= lock_ign_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    lock_cnt_nxt = '0;
    lock_ign_nxt = 1'b0;
    c_win        = 1'b0;
    d_win        = 1'b0;
    last_win_nxt = last_win_d;
    case (state)
      ST_ARB: begin
        c_win = rr_c;
        d_win = rr_d;
        if (c_win || d_win) last_win_nxt = d_win;
        // The cycle right after a timeout must not re-lock, so a waiting core gets through.
        if (d_win && d_lock && !lock_ign) state_nxt = ST_LOCKED;
      end
      ST_LOCKED: begin
        d_win = d_req;
        if (d_win) last_win_nxt = 1'b1;
        if (lock_tmo) begin
          state_nxt    = ST_ARB;
          last_win_nxt = 1'b1;
          lock_ign_nxt = 1'b1;
        end else if (!d_lock) begin
          state_nxt = ST_ARB;
        end else begin
          lock_cnt_nxt = lock_cnt + 1'b1;
        end
      end
      default: state_nxt = ST_ARB;
    endcase
  end
`else
  always_comb begin
    c_win        = rr_c;
    d_win        = rr_d;
    last_win_nxt = (rr_c || rr_d) ? rr_d : last_win_d;
  end
`endif

  assign c_gnt       = rst && c_win;
  assign d_gnt       = rst && d_win;
  assign c_stall     = c_req && !c_gnt;
  assign mem_addr    = d_win ? d_addr : c_addr;
  assign mem_wr_data = d_win ? d_wdata : c_wdata;
  assign mem_write   = rst && ((c_win && c_we) || (d_win && d_we));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_win_d   <= 1'b1;
      c_rvalid     <= 1'b0;
      d_rvalid     <= 1'b0;
      c_rdata      <= '0;
      d_rdata      <= '0;
      conflict_cnt <= '0;
    end else begin
      last_win_d <= last_win_nxt;
      c_rvalid   <= c_win && !c_we;
      d_rvalid   <= d_win && !d_we;
      if (c_win && !c_we) c_rdata <= mem_rd_data;
      if (d_win && !d_we) d_rdata <= mem_rd_data;
      if (c_req && d_req && (conflict_cnt != '1)) conflict_cnt <= conflict_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_risc_v_mike_dmem_arbiter.sv
// Self-checking bench for risc_v_mike_dmem_arbiter: scoreboard of expected read returns,
// a small memory model, and a second instance with a 4-bit contention counter.
module tb_risc_v_mike_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        c_req, c_we, d_req, d_we, d_lock;
  logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
  logic        c_gnt, c_rvalid, c_stall, d_gnt, d_rvalid, mem_write;
  logic [31:0] c_rdata, d_rdata, mem_addr, mem_wr_data, mem_rd_data;
  logic [15:0] conflict_cnt;
  logic        s_c_gnt, s_c_rvalid, s_c_stall, s_d_gnt, s_d_rvalid, s_mem_write;
  logic [31:0] s_c_rdata, s_d_rdata, s_mem_addr, s_mem_wr_data;
  logic [3:0]  s_conflict_cnt;

  logic [31:0] mem     [256];
  logic [31:0] exp_mem [256];

  typedef struct {logic is_d; logic [31:0] data;} exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign mem_rd_data = mem[mem_addr[7:0]];
  always @(posedge clk) if (mem_write) mem[mem_addr[7:0]] <= mem_wr_data;

  risc_v_mike_dmem_arbiter #(
`ifdef RISC_V_MIKE_ARB_LOCK_EN
    .LOCK_MAX(8),
`endif
    .ADDR_W(32), .DATA_W(32), .CNT_W(16)
  ) u_dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_stall(c_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
`ifdef RISC_V_MIKE_ARB_LOCK_EN
    .d_lock(d_lock),
`endif
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_write(mem_write), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data), .conflict_cnt(conflict_cnt)
  );

  risc_v_mike_dmem_arbiter #(
`ifdef RISC_V_MIKE_ARB_LOCK_EN
    .LOCK_MAX(8),
`endif
    .ADDR_W(32), .DATA_W(32), .CNT_W(4)
  ) u_sat (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(s_c_gnt), .c_rvalid(s_c_rvalid), .c_rdata(s_c_rdata), .c_stall(s_c_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
`ifdef RISC_V_MIKE_ARB_LOCK_EN
    .d_lock(d_lock),
`endif
    .d_gnt(s_d_gnt), .d_rvalid(s_d_rvalid), .d_rdata(s_d_rdata),
    .mem_addr(s_mem_addr), .mem_write(s_mem_write), .mem_wr_data(s_mem_wr_data),
    .mem_rd_data(mem_rd_data), .conflict_cnt(s_conflict_cnt)
  );

  task automatic idle_inputs();
    c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_lock = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1;
    sb.delete();
  endtask

  task automatic test_reset();
    rst = 0;
    idle_inputs();
    c_req = 1; c_we = 1; d_req = 1; d_we = 1;
    @(negedge clk);
    #1;
    n_checks++;
    if (c_gnt !== 1'b0 || d_gnt !== 1'b0 || mem_write !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_grants: c_gnt=%b d_gnt=%b mem_write=%b, required all 0", c_gnt, d_gnt, mem_write);
    end
    n_checks++;
    if (c_rvalid !== 1'b0 || d_rvalid !== 1'b0 || c_rdata !== 32'h0 || d_rdata !== 32'h0 || conflict_cnt !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_regs: c_rv=%b d_rv=%b c_rd=%h d_rd=%h cnt=%0d, required zeros",
               c_rvalid, d_rvalid, c_rdata, d_rdata, conflict_cnt);
    end
    apply_reset();
  endtask

  task automatic test_core_read();
    exp_t e;
    apply_reset();
    @(negedge clk);
    c_req = 1; c_we = 0; c_addr = 32'h10;
    #1;
    n_checks++;
    if (c_gnt !== 1'b1 || d_gnt !== 1'b0 || mem_addr !== 32'h10 || mem_write !== 1'b0) begin
      n_fail++;
      $display("FAIL core_read_grant: c_gnt=%b d_gnt=%b mem_addr=%h mem_write=%b, required 1 0 00000010 0",
               c_gnt, d_gnt, mem_addr, mem_write);
    end
    sb.push_back('{is_d: 1'b0, data: exp_mem[8'h10]});
    @(negedge clk);
    idle_inputs();
    #1;
    e = sb.pop_front();
    n_checks++;
    if (c_rvalid !== 1'b1 || d_rvalid !== 1'b0 || c_rdata !== e.data) begin
      n_fail++;
      $display("FAIL core_read_data: c_rv=%b d_rv=%b c_rdata=%h, required 1 0 %h", c_rvalid, d_rvalid, c_rdata, e.data);
    end
  endtask

  task automatic test_round_robin();
    int   ci, di;
    logic exp_c;
    exp_t e;
    logic has_e;
    apply_reset();
    ci = 0; di = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      c_req = 1; c_we = 0; c_addr = 32'h30 + 32'(ci);
      d_req = 1; d_we = 0; d_addr = 32'h60 + 32'(di);
      #1;
      has_e = (sb.size() > 0);
      if (has_e) e = sb.pop_front();
      n_checks++;
      if (c_rvalid !== (has_e && !e.is_d) || d_rvalid !== (has_e && e.is_d)) begin
        n_fail++;
        $display("FAIL rr_rvalid[%0d]: c_rv=%b d_rv=%b, required %b %b", i, c_rvalid, d_rvalid,
                 has_e && !e.is_d, has_e && e.is_d);
      end
      if (has_e) begin
        n_checks++;
        if ((e.is_d ? d_rdata : c_rdata) !== e.data) begin
          n_fail++;
          $display("FAIL rr_rdata[%0d]: got %h, required %h", i, e.is_d ? d_rdata : c_rdata, e.data);
        end
      end
      exp_c = (i % 2 == 0);
      n_checks++;
      if (c_gnt !== exp_c || d_gnt !== !exp_c || c_stall !== !exp_c ||
          mem_addr !== (exp_c ? c_addr : d_addr)) begin
        n_fail++;
        $display("FAIL rr_grant[%0d]: c_gnt=%b d_gnt=%b c_stall=%b mem_addr=%h, required %b %b %b %h",
                 i, c_gnt, d_gnt, c_stall, mem_addr, exp_c, !exp_c, !exp_c, exp_c ? c_addr : d_addr);
      end
      sb.push_back('{is_d: !exp_c, data: exp_mem[exp_c ? 8'(8'h30 + ci) : 8'(8'h60 + di)]});
      if (exp_c) ci++; else di++;
    end
    @(negedge clk);
    idle_inputs();
    #1;
    e = sb.pop_front();
    n_checks++;
    if (d_rvalid !== 1'b1 || c_rvalid !== 1'b0 || d_rdata !== e.data) begin
      n_fail++;
      $display("FAIL rr_last_read: d_rv=%b c_rv=%b d_rdata=%h, required 1 0 %h", d_rvalid, c_rvalid, d_rdata, e.data);
    end
    n_checks++;
    if (conflict_cnt !== 16'd6) begin
      n_fail++;
      $display("FAIL rr_conflict_cnt: got %0d, required 6", conflict_cnt);
    end
  endtask

  task automatic test_write_then_read();
    exp_t e;
    apply_reset();
    @(negedge clk);
    c_req = 1; c_we = 1; c_addr = 32'h20; c_wdata = 32'h55;
    d_req = 1; d_we = 0; d_addr = 32'h20; d_wdata = 32'hFFFF_FFFF;
    exp_mem[8'h20] = 32'h55;
    #1;
    n_checks++;
    if (c_gnt !== 1'b1 || d_gnt !== 1'b0 || mem_write !== 1'b1 || mem_addr !== 32'h20 || mem_wr_data !== 32'h55) begin
      n_fail++;
      $display("FAIL wr_core_beat: c_gnt=%b d_gnt=%b mem_write=%b addr=%h wdata=%h, required 1 0 1 00000020 00000055",
               c_gnt, d_gnt, mem_write, mem_addr, mem_wr_data);
    end
    @(negedge clk);
    c_we = 0; c_addr = 32'h24;
    #1;
    n_checks++;
    if (d_gnt !== 1'b1 || c_gnt !== 1'b0 || c_stall !== 1'b1 || mem_write !== 1'b0 || c_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_debug_beat: d_gnt=%b c_gnt=%b c_stall=%b mem_write=%b c_rv=%b, required 1 0 1 0 0",
               d_gnt, c_gnt, c_stall, mem_write, c_rvalid);
    end
    sb.push_back('{is_d: 1'b1, data: exp_mem[8'h20]});
    @(negedge clk);
    d_req = 0;
    #1;
    e = sb.pop_front();
    n_checks++;
    if (d_rvalid !== 1'b1 || c_rvalid !== 1'b0 || d_rdata !== e.data) begin
      n_fail++;
      $display("FAIL wr_read_back: d_rv=%b c_rv=%b d_rdata=%h, required 1 0 %h", d_rvalid, c_rvalid, d_rdata, e.data);
    end
    n_checks++;
    if (c_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_core_alone: c_gnt=%b, required 1", c_gnt);
    end
    sb.push_back('{is_d: 1'b0, data: exp_mem[8'h24]});
    @(negedge clk);
    idle_inputs();
    #1;
    e = sb.pop_front();
    n_checks++;
    if (c_rvalid !== 1'b1 || d_rvalid !== 1'b0 || c_rdata !== e.data) begin
      n_fail++;
      $display("FAIL wr_core_read: c_rv=%b d_rv=%b c_rdata=%h, required 1 0 %h", c_rvalid, d_rvalid, c_rdata, e.data);
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      c_req = 1; d_req = 1; c_we = 0; d_we = 0; c_addr = 32'h40; d_addr = 32'h44;
      #1;
      if (i == 16) begin
        n_checks++;
        if (s_conflict_cnt !== 4'd15) begin
          n_fail++;
          $display("FAIL sat_reach: cnt=%0d, required 15", s_conflict_cnt);
        end
      end
    end
    @(negedge clk);
    idle_inputs();
    #1;
    n_checks++;
    if (s_conflict_cnt !== 4'd15 || conflict_cnt !== 16'd20) begin
      n_fail++;
      $display("FAIL sat_hold: cnt4=%0d cnt16=%0d, required 15 20", s_conflict_cnt, conflict_cnt);
    end
  endtask

  task automatic test_reset_mid_access();
    apply_reset();
    @(negedge clk);
    c_req = 1; c_we = 0; c_addr = 32'h10;
    @(posedge clk);
    #1;
    n_checks++;
    if (c_rvalid !== 1'b1 || c_rdata !== exp_mem[8'h10]) begin
      n_fail++;
      $display("FAIL mid_pre: c_rv=%b c_rdata=%h, required 1 %h", c_rvalid, c_rdata, exp_mem[8'h10]);
    end
    @(negedge clk);
    rst = 0;
    c_req = 1; c_we = 1; c_wdata = 32'h1234; d_req = 1; d_we = 1;
    #1;
    n_checks++;
    if (c_rvalid !== 1'b0 || d_rvalid !== 1'b0 || c_rdata !== 32'h0 || d_rdata !== 32'h0 ||
        c_gnt !== 1'b0 || d_gnt !== 1'b0 || mem_write !== 1'b0 || conflict_cnt !== 16'h0) begin
      n_fail++;
      $display("FAIL mid_reset: c_rv=%b d_rv=%b c_rd=%h d_rd=%h c_gnt=%b d_gnt=%b wr=%b cnt=%0d, required all 0",
               c_rvalid, d_rvalid, c_rdata, d_rdata, c_gnt, d_gnt, mem_write, conflict_cnt);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (mem[8'h10] !== exp_mem[8'h10]) begin
      n_fail++;
      $display("FAIL mid_no_write: mem[0x10]=%h, required %h", mem[8'h10], exp_mem[8'h10]);
    end
    apply_reset();
  endtask

`ifdef RISC_V_MIKE_ARB_LOCK_EN
  task automatic test_lock_release();
    logic exp_c;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      c_req = 1; c_we = 0; c_addr = 32'h10;
      d_req = 1; d_we = 1; d_addr = 32'hF0; d_wdata = 32'(i);
      d_lock = (i >= 1 && i <= 5);
      #1;
      exp_c = (i == 0 || i == 7);
      n_checks++;
      if (c_gnt !== exp_c || d_gnt !== !exp_c) begin
        n_fail++;
        $display("FAIL lock_release[%0d]: c_gnt=%b d_gnt=%b, required %b %b", i, c_gnt, d_gnt, exp_c, !exp_c);
      end
    end
    idle_inputs();
  endtask

  task automatic test_lock_timeout();
    logic exp_c;
    apply_reset();
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      c_req = 1; c_we = 0; c_addr = 32'h10;
      d_req = 1; d_we = 1; d_addr = 32'hF4; d_wdata = 32'(i);
      d_lock = 1;
      #1;
      exp_c = (i == 0 || i == 10);
      n_checks++;
      if (c_gnt !== exp_c || d_gnt !== !exp_c) begin
        n_fail++;
        $display("FAIL lock_timeout[%0d]: c_gnt=%b d_gnt=%b, required %b %b", i, c_gnt, d_gnt, exp_c, !exp_c);
      end
    end
    idle_inputs();
  endtask
`endif

  initial begin
    rst = 0;
    idle_inputs();
    for (int k = 0; k < 256; k++) begin
      mem[k]     = 32'hA500_0000 | 32'(k);
      exp_mem[k] = 32'hA500_0000 | 32'(k);
    end
    mem[8'h10]     = 32'hDEADBEEF;
    exp_mem[8'h10] = 32'hDEADBEEF;
    test_reset();
    test_core_read();
    test_round_robin();
    test_write_then_read();
    test_saturation();
    test_reset_mid_access();
`ifdef RISC_V_MIKE_ARB_LOCK_EN
    test_lock_release();
    test_lock_timeout();
`endif
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
